// File: rtl/channel_readout_arbiter.sv
// channel_readout_arbiter
// Round-robin arbiter that shares the single event-FIFO write port among
// NUMCHANNELS per-channel local FIFOs. One channel is granted per cycle; its
// packet is captured into a registered write towards the shared FIFO.
//
// Optional build feature: define CHANNEL_READOUT_ARBITER_STATS_EN to add the
// stats_clear input and the saturating grant_count / stall_count outputs.
// Without the macro those ports and counters do not exist. The core
// arbitration behaviour is the same in both builds.
module channel_readout_arbiter #(
  parameter int NUMCHANNELS = 64,
  parameter int WIDTH       = 64,
  parameter int PTR_W       = 6
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           arb_enable,
  input  logic [NUMCHANNELS-1:0]         req,
  input  logic [NUMCHANNELS*WIDTH-1:0]   packet_in,
  input  logic                           fifo_full,
  output logic [NUMCHANNELS-1:0]         grant,
  output logic                           fifo_wr_en,
  output logic [WIDTH-1:0]               fifo_data,
`ifdef CHANNEL_READOUT_ARBITER_STATS_EN
  input  logic                           stats_clear,
  output logic [15:0]                    grant_count,
  output logic [15:0]                    stall_count,
`endif
  output logic                           busy
);

  // Lowest set bit of a request vector. The loop runs from the top down so
  // that the last assignment made is the lowest index.
  function automatic logic [PTR_W-1:0] lowest_set(input logic [NUMCHANNELS-1:0] v);
    lowest_set = '0;
    for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = PTR_W'(i);
    end
  endfunction

  // Pointer successor with explicit wrap so non power-of-two channel counts
  // still rotate correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    if (w == PTR_W'(NUMCHANNELS - 1)) next_ptr = '0;
    else                              next_ptr = w + 1'b1;
  endfunction

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc16 = v;
    else               sat_inc16 = v + 16'd1;
  endfunction

  // Registered stage state
  logic [NUMCHANNELS-1:0] grant_p1;
  logic                   vld_p1;
  logic [WIDTH-1:0]       data_p1;
  logic [PTR_W-1:0]       ptr_p1;

  // Combinational selection state
  logic [NUMCHANNELS-1:0] eligible;
  logic [NUMCHANNELS-1:0] hi_mask;
  logic [NUMCHANNELS-1:0] eligible_hi;
  logic [PTR_W-1:0]       win;
  logic                   issue;
  logic [WIDTH-1:0]       win_packet;

  // ---- stage 0: eligibility, rotating selection and issue decision ----
  // The channel granted this cycle is masked so it can present its next
  // packet before being sampled again. The search prefers channels at or
  // above the pointer and falls back to a plain priority encode (the wrap).
  always_comb begin
    eligible    = req & ~grant_p1;
    hi_mask     = {NUMCHANNELS{1'b1}} << ptr_p1;
    eligible_hi = eligible & hi_mask;
    if (|eligible_hi) win = lowest_set(eligible_hi);
    else              win = lowest_set(eligible);
    issue      = arb_enable & ~fifo_full & (|eligible);
    win_packet = packet_in[win*WIDTH +: WIDTH];
  end

  // ---- stage 1: grant, captured packet and write strobe ----
  // Control and data registers for the shared-FIFO write; data and pointer
  // hold whenever nothing is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_p1 <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ptr_p1   <= '0;
    end else if (issue) begin
      grant_p1 <= NUMCHANNELS'(1) << win;
      vld_p1   <= 1'b1;
      data_p1  <= win_packet;
      ptr_p1   <= next_ptr(win);
    end else begin
      grant_p1 <= '0;
      vld_p1   <= 1'b0;
    end
  end

  assign grant      = grant_p1;
  assign fifo_wr_en = vld_p1;
  assign fifo_data  = data_p1;

  // Activity flag; forced low while reset is held so it clears immediately.
  assign busy = reset_n & ((|req) | vld_p1);

`ifdef CHANNEL_READOUT_ARBITER_STATS_EN
  logic [15:0] grant_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        stall_cycle;

  assign stall_cycle = (|req) & arb_enable & fifo_full;

  // Saturating statistics with a synchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (stats_clear) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue)       grant_cnt_q <= sat_inc16(grant_cnt_q);
      if (stall_cycle) stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign grant_count = grant_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Testbench for channel_readout_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue/array-level model of the round-robin service rule.
module tb_channel_readout_arbiter;
  localparam int N = 64;
  localparam int W = 64;

  logic              clk;
  logic              reset_n;
  logic              arb_enable;
  logic [N-1:0]      req;
  logic [N*W-1:0]    packet_in;
  logic              fifo_full;
  logic [N-1:0]      grant;
  logic              fifo_wr_en;
  logic [W-1:0]      fifo_data;
  logic              busy;

  logic [W-1:0]      pkt [N];

  channel_readout_arbiter #(.NUMCHANNELS(N), .WIDTH(W), .PTR_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .arb_enable(arb_enable), .req(req),
    .packet_in(packet_in), .fifo_full(fifo_full), .grant(grant),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy)
  );

  always_comb begin
    packet_in = '0;
    for (int i = 0; i < N; i++) packet_in[i*W +: W] = pkt[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int         m_ptr;
  int         m_gnt;
  bit         m_wr;
  logic [W-1:0] m_data;
  int         wlog[$];

  // requester behaviour knobs
  int drop_pct;
  int new_pct;
  bit rand_pkt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_gnt  = -1;
    m_wr   = 0;
    m_data = '0;
  endtask

  // One clock cycle: predict, advance, compare, then act as the requesters.
  task automatic step();
    logic [N-1:0] e;
    logic [N-1:0] exp_g;
    int w;
    e = req;
    if (m_gnt >= 0) e[m_gnt] = 1'b0;
    w = -1;
    if (arb_enable && !fifo_full) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && e[c]) w = c;
      end
    end
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_gnt  = w;
      m_wr   = 1;
      m_data = pkt[w];
      m_ptr  = (w + 1) % N;
    end else begin
      m_gnt = -1;
      m_wr  = 0;
    end
    exp_g = '0;
    if (m_gnt >= 0) exp_g[m_gnt] = 1'b1;
    chk("grant", grant, exp_g);
    chk("wr_en", fifo_wr_en, m_wr);
    chk("data", fifo_data, m_data);
    if (m_wr) wlog.push_back(m_gnt);
    if (m_gnt >= 0) begin
      if ($urandom_range(99) < drop_pct) req[m_gnt] = 1'b0;
      else if (rand_pkt) pkt[m_gnt] = rnd64();
    end
    if (new_pct > 0) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(99) < new_pct) begin
          req[i] = 1'b1;
          pkt[i] = rnd64();
        end
      end
    end
    #1;
    chk("busy", busy, (|req) | m_wr);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req        = '0;
    fifo_full  = 1'b0;
    arb_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_data", fifo_data, '0);
    chk("rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_order[6];
    logic [N-1:0] seen;
    exp_order = '{0, 5, 63, 0, 5, 63};
    for (int i = 0; i < N; i++) pkt[i] = '0;
    drop_pct = 100; new_pct = 0; rand_pkt = 0;
    model_reset();
    do_reset();

    // single request on channel 5
    wlog.delete();
    pkt[5] = 64'hA5A5_0000_0000_0005;
    req[5] = 1'b1;
    step();
    chk("single_grant", grant, 64'h20);
    chk("single_data", fifo_data, 64'hA5A5_0000_0000_0005);
    repeat (3) step();
    chk("single_writes", wlog.size(), 1);
    // pointer now at 6: channel 7 must win over channel 3
    pkt[3] = 64'd3; pkt[7] = 64'd7;
    req[3] = 1'b1; req[7] = 1'b1;
    step();
    chk("ptr6_first", grant, 64'h80);
    step();
    chk("ptr6_second", grant, 64'h08);
    step();

    // rotation and wrap with three persistent requesters
    do_reset();
    drop_pct = 0; rand_pkt = 0;
    pkt[0] = 64'd0; pkt[5] = 64'd5; pkt[63] = 64'd63;
    req[0] = 1'b1; req[5] = 1'b1; req[63] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rot_wr", fifo_wr_en, 1'b1);
      chk("rot_order", fifo_data, 64'(exp_order[k]));
    end

    // lone persistent requester
    do_reset();
    wlog.delete();
    pkt[10] = 64'h10;
    req[10] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("lone_alt", fifo_wr_en, (k % 2) == 0);
    end
    chk("lone_writes", wlog.size(), 5);

    // backpressure with every channel requesting
    drop_pct = 100;
    for (int i = 0; i < N; i++) pkt[i] = rnd64();
    step();
    req = '1;
    fifo_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("bp_hold", fifo_wr_en, 1'b0);
    end
    fifo_full = 1'b0;
    wlog.delete();
    for (int k = 0; k < N; k++) begin
      step();
      chk("bp_drain", fifo_wr_en, 1'b1);
    end
    seen = '0;
    foreach (wlog[i]) seen[wlog[i]] = 1'b1;
    chk("bp_count", wlog.size(), N);
    chk("bp_cover", seen, '1);
    step();

    // disable during a write, then reset mid-stream
    do_reset();
    drop_pct = 0; rand_pkt = 1;
    pkt[3] = rnd64(); pkt[4] = rnd64();
    req[3] = 1'b1; req[4] = 1'b1;
    step();
    chk("dis_grant3", grant, 64'h08);
    arb_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dis_idle", fifo_wr_en, 1'b0);
    end
    arb_enable = 1'b1;
    step();
    chk("dis_resume4", grant, 64'h10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, '0);
    chk("mid_rst_wr", fifo_wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rst_restart", grant, 64'h08);

    // randomized traffic
    do_reset();
    drop_pct = 50; new_pct = 3; rand_pkt = 1;
    for (int k = 0; k < 1500; k++) begin
      arb_enable = ($urandom_range(7) != 0);
      fifo_full  = ($urandom_range(4) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/channel_readout_arbiter.md
Name: channel_readout_arbiter

Overview:
- Round-robin arbiter sharing the single event FIFO write port among the NUMCHANNELS per-channel local FIFOs in the digital core.
- Each channel with a completed 64-bit packet raises a request.
- The arbiter grants one channel per cycle, captures that channel's packet and issues one registered write to the shared FIFO.
- Pointer-based rotation gives fair service. Writes are throttled by the shared FIFO's full flag.

Parameters:
- NUMCHANNELS, 64, number of requesting channels.
- WIDTH, 64, packet width in bits.
- PTR_W, 6, width of the round-robin pointer; equals clog2(NUMCHANNELS).

Ports:
- clk  input  1  master clock.
- reset_n  input  1  asynchronous active-low reset.
- arb_enable  input  1  high permits new grants.
- req  input  NUMCHANNELS  per-channel request; bit i high means channel i holds a valid packet.
- packet_in  input  NUMCHANNELS*WIDTH  packets; channel i occupies bits [i*WIDTH +: WIDTH].
- fifo_full  input  1  shared FIFO cannot accept a further write beyond the one in flight. Asserted with one entry of slack.
- grant  output  NUMCHANNELS  one-hot acknowledge, high for one cycle.
- fifo_wr_en  output  1  write strobe to the shared FIFO.
- fifo_data  output  WIDTH  packet to write.
- busy  output  1  high when any req bit is high, or fifo_wr_en is high.

Behaviour:
- Reset: clock and reset are one clock, asynchronous active-low reset (clk, reset_n). Reset clears grant, fifo_wr_en and fifo_data to 0, clears the pointer to 0, and clears busy to 0. Reset mid-write drops the in-flight packet; no partial state survives.
- Eligible set: E = req & ~grant. The channel granted in the current cycle is masked, so a channel gets at most one grant every two cycles.
- Selection (combinational, cycle N): the winner w is the lowest index in E at or above the pointer. If none exists, the search wraps to index 0 upward. With the pointer at 0 the search is a plain priority encoder.
- Issue condition: arb_enable & ~fifo_full & (E != 0).
- When issue is true, at the clk edge ending cycle N:
  - grant <= onehot(w);
  - fifo_data <= packet_in[w*WIDTH +: WIDTH];
  - fifo_wr_en <= 1;
  - pointer <= (w+1) mod NUMCHANNELS.
- When issue is false: grant <= 0, fifo_wr_en <= 0, and fifo_data and the pointer hold.
- Latency: request to grant and to write is 1 cycle. Grant and fifo_wr_en are coincident (cycle N+1).
- Requester handshake:
  - On seeing grant[i], channel i either deasserts req[i] or presents its next packet on packet_in and keeps req[i] high.
  - The arbiter never samples packet_in[i] in a cycle where grant[i] is high.
  - req must not drop without a grant; dropping early is a protocol violation and the result is undefined.
- fifo_full:
  - Sampled combinationally in cycle N.
  - If high, no grant is issued and requests wait without loss.
  - A write already registered (fifo_wr_en high) always completes; the one-entry slack covers it.
- arb_enable low: no new grants; a write in flight completes; the pointer holds.
- Pointer wrap: w = NUMCHANNELS-1 sets the pointer to 0.
- Throughput:
  - One write per cycle while at least two channels request.
  - A single persistent requester gets a write every other cycle.
- Simultaneous events: fifo_full and arb_enable low in the same cycle gives no issue. Reset has priority over everything.
- busy is combinational: |req | fifo_wr_en.

Optional Feature:
- Macro: CHANNEL_READOUT_ARBITER_STATS_EN.
- When defined, two extra output ports are added:
  - grant_count, 16 bits: saturating count of issued writes.
  - stall_count, 16 bits: saturating count of cycles with (req != 0) & arb_enable & fifo_full.
- Both counters reset to 0, stop at 16'hFFFF, and are cleared synchronously by a third added input, stats_clear (1 bit).
- When not defined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Single request: reset, then req[5]=1 with packet_in[5]=64'hA5A5_0000_0000_0005, then drop req on grant. Expect grant[5] and fifo_wr_en=1 in the following cycle with fifo_data=64'hA5A5_0000_0000_0005, exactly one write, and the pointer at 6.
- Rotation and wrap: req bits 0, 5 and 63 held high, each channel presenting its index. Expect writes in order 0, 5, 63, 0, 5, 63 with back-to-back grants and no gaps.
- Lone persistent requester: req[10] held high for 10 cycles. Expect 5 writes, with grant alternating 1,0,1,0.
- Backpressure: all 64 channels request and fifo_full=1 for 20 cycles. Expect grant=0 and fifo_wr_en=0 throughout. After fifo_full drops, expect 64 consecutive writes covering every channel exactly once.
- Disable and reset: arb_enable falls during the write of channel 3. Expect that write to complete and no further grants. Asserting reset_n=0 mid-stream clears grant, fifo_wr_en and busy immediately; after release, service restarts from channel 0.
- Stats (CHANNEL_READOUT_ARBITER_STATS_EN): 100 writes plus 7 stall cycles give grant_count=100 and stall_count=7. A stats_clear pulse returns both counters to 0. Forced saturation holds at 16'hFFFF.
